// File: rtl/axi_read_arbiter_rr.sv
// Combinational round-robin pick: first requester above last_grant, wrapping.
module axi_read_arbiter_rr #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  int idx;

  // Walk from the farthest offset down so the nearest request wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % N;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read master among S_COUNT requesters; the requester index is
// prefixed to ARID and R beats are steered back by that prefix.
module axi_read_arbiter #(
  parameter int S_COUNT         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int M_ID_WIDTH      = ID_WIDTH + $clog2(S_COUNT),
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [S_COUNT*ID_WIDTH-1:0]  s_axi_arid,
  input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [S_COUNT*8-1:0]         s_axi_arlen,
  input  logic [S_COUNT*3-1:0]         s_axi_arsize,
  input  logic [S_COUNT*2-1:0]         s_axi_arburst,
  input  logic [S_COUNT-1:0]           s_axi_arlock,
  input  logic [S_COUNT*4-1:0]         s_axi_arcache,
  input  logic [S_COUNT*3-1:0]         s_axi_arprot,
  input  logic [S_COUNT-1:0]           s_axi_arvalid,
  output logic [S_COUNT-1:0]           s_axi_arready,
  output logic [S_COUNT*ID_WIDTH-1:0]  s_axi_rid,
  output logic [S_COUNT*DATA_WIDTH-1:0] s_axi_rdata,
  output logic [S_COUNT*2-1:0]         s_axi_rresp,
  output logic [S_COUNT-1:0]           s_axi_rlast,
  output logic [S_COUNT-1:0]           s_axi_rvalid,
  input  logic [S_COUNT-1:0]           s_axi_rready,
  output logic [M_ID_WIDTH-1:0]        m_axi_arid,
  output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arlock,
  output logic [3:0]                   m_axi_arcache,
  output logic [2:0]                   m_axi_arprot,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  input  logic [M_ID_WIDTH-1:0]        m_axi_rid,
  input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready
);

  localparam int CL_S_COUNT = $clog2(S_COUNT);
  localparam int CNT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {STATE_IDLE, STATE_WAIT} state_t;

  state_t                             state;
  logic [CL_S_COUNT-1:0]              last_grant;
  logic [CL_S_COUNT-1:0]              grant_idx;
  logic                               grant_valid;
  logic                               ar_accept;
  logic                               r_last_hs;
  logic [S_COUNT-1:0]                 eligible;
  logic [S_COUNT-1:0]                 sel_hit;
  logic [S_COUNT-1:0][CNT_WIDTH-1:0]  cnt;

  axi_read_arbiter_rr #(.N(S_COUNT), .IW(CL_S_COUNT)) u_rr (
    .req         (eligible),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Accept is gated by rst so the lanes see arready low while in reset.
  assign ar_accept = (state == STATE_IDLE) && grant_valid && !rst;

  always_comb begin
    s_axi_arready = '0;
    if (ar_accept) s_axi_arready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= STATE_IDLE;
      last_grant    <= CL_S_COUNT'(S_COUNT - 1);
      m_axi_arvalid <= 1'b0;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
      m_axi_arlock  <= 1'b0;
      m_axi_arcache <= '0;
      m_axi_arprot  <= '0;
    end else begin
      case (state)
        STATE_IDLE: if (grant_valid) begin
          m_axi_arid    <= {grant_idx, s_axi_arid[grant_idx*ID_WIDTH +: ID_WIDTH]};
          m_axi_araddr  <= s_axi_araddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          m_axi_arlen   <= s_axi_arlen[grant_idx*8 +: 8];
          m_axi_arsize  <= s_axi_arsize[grant_idx*3 +: 3];
          m_axi_arburst <= s_axi_arburst[grant_idx*2 +: 2];
          m_axi_arlock  <= s_axi_arlock[grant_idx];
          m_axi_arcache <= s_axi_arcache[grant_idx*4 +: 4];
          m_axi_arprot  <= s_axi_arprot[grant_idx*3 +: 3];
          m_axi_arvalid <= 1'b1;
          last_grant    <= grant_idx;
          state         <= STATE_WAIT;
        end
        STATE_WAIT: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          state         <= STATE_IDLE;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  // An out-of-range prefix matches no lane: the beat is sunk and no counter moves.
  assign m_axi_rready = ~(|sel_hit) | (|(sel_hit & s_axi_rready));
  assign r_last_hs    = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  for (genvar p = 0; p < S_COUNT; p++) begin : g_lane
    logic inc, dec;

    assign sel_hit[p]  = (m_axi_rid[M_ID_WIDTH-1:ID_WIDTH] == CL_S_COUNT'(p));
    assign eligible[p] = s_axi_arvalid[p] && (cnt[p] < CNT_WIDTH'(MAX_OUTSTANDING));
    assign inc         = ar_accept && (grant_idx == CL_S_COUNT'(p));
    assign dec         = r_last_hs && sel_hit[p];

    always_ff @(posedge clk) begin
      if (rst)                                cnt[p] <= '0;
      else if (inc && !dec)                   cnt[p] <= cnt[p] + CNT_WIDTH'(1);
      else if (dec && !inc && cnt[p] != '0)   cnt[p] <= cnt[p] - CNT_WIDTH'(1);
    end

    assign s_axi_rvalid[p]                          = m_axi_rvalid && sel_hit[p];
    assign s_axi_rid[p*ID_WIDTH +: ID_WIDTH]        = m_axi_rid[ID_WIDTH-1:0];
    assign s_axi_rdata[p*DATA_WIDTH +: DATA_WIDTH]  = m_axi_rdata;
    assign s_axi_rresp[p*2 +: 2]                    = m_axi_rresp;
    assign s_axi_rlast[p]                           = m_axi_rlast;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Round-robin arbiter that shares one AXI4 read master port among S_COUNT AXI4 read requesters. It sits upstream of an axi_register slice on the shared memory path. Each granted AR gets the requester index prepended to its ID, and R beats are routed back by decoding that prefix. A per-port outstanding-burst limit keeps any one requester from monopolising the downstream read queue.

## Interface
Parameters:
- S_COUNT, 2, number of requester ports (≥2)
- DATA_WIDTH, 32, R data width
- ADDR_WIDTH, 32, address width
- ID_WIDTH, 8, requester-side ID width
- M_ID_WIDTH, ID_WIDTH+$clog2(S_COUNT), master-side ID width (derived, do not override)
- MAX_OUTSTANDING, 4, maximum bursts in flight per port (≥1)

Ports (s_* buses are S_COUNT concatenated lanes; port p occupies slice p):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  S_COUNT×(ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3)  AR fields
- s_axi_arvalid  in  S_COUNT  AR valid
- s_axi_arready  out  S_COUNT  AR ready
- s_axi_rid  out  S_COUNT×ID_WIDTH  R ID
- s_axi_rdata  out  S_COUNT×DATA_WIDTH  R data
- s_axi_rresp  out  S_COUNT×2  R response
- s_axi_rlast  out  S_COUNT  R last
- s_axi_rvalid  out  S_COUNT  R valid
- s_axi_rready  in  S_COUNT  R ready
- m_axi_arid  out  M_ID_WIDTH  {port index, s_arid}
- m_axi_araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  same widths as above  registered AR fields
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rid  in  M_ID_WIDTH  R ID
- m_axi_rdata/rresp/rlast/rvalid  in  DATA_WIDTH/2/1/1  R beat
- m_axi_rready  out  1  R ready

## Operation
- Two-state AR FSM:
  - IDLE: eligible[p] = s_arvalid[p] && cnt[p] < MAX_OUTSTANDING. If any port is eligible, grant the first eligible port searching upward (with wrap) from last_grant+1. In the same cycle assert s_arready[grant] for exactly one cycle, load all AR fields into the output register, set m_arid = {grant, s_arid}, set m_arvalid, set last_grant = grant, and go to WAIT.
  - WAIT: hold the output register. When m_arvalid && m_arready, clear m_arvalid and return to IDLE. No grants are made while in WAIT.
- last_grant resets to S_COUNT-1, so port 0 has first priority after reset.
- Outstanding counters: cnt[p] has width $clog2(MAX_OUTSTANDING+1).
  - +1 on AR acceptance from port p.
  - −1 on an R handshake with rlast routed to port p.
  - Both in the same cycle: no change.
  - Counters never wrap. An rlast to a port whose count is 0 leaves the count at 0.
- R routing (combinational, no storage):
  - sel = m_rid[M_ID_WIDTH-1:ID_WIDTH]
  - s_rvalid[p] = m_rvalid && sel==p
  - s_rid/rdata/rresp/rlast are broadcast to all lanes, with s_rid = m_rid[ID_WIDTH-1:0]
  - m_rready = s_rready[sel]
  - If sel ≥ S_COUNT (non-power-of-2 S_COUNT): m_rready=1, the beat is discarded, and no counter changes.

## Timing
- Reset values: m_axi_arvalid=0, s_axi_arready=0, all m_ar fields 0, state=IDLE, all cnt=0. R outputs follow inputs combinationally (s_rvalid=0 while m_rvalid=0).
- AR latency: s_arvalid seen in IDLE at cycle N → s_arready high at N → m_arvalid high from N+1.
- Peak AR throughput is one burst per 2 cycles (IDLE↔WAIT), which is acceptable because AR is a low-rate channel.
- R path adds zero latency and no bubbles.
- Reset asserted mid-burst returns to the reset state on the next edge. In-flight bursts are forgotten, and the downstream must also be reset.
- m_arvalid, once set, never drops before m_arready, as AXI requires.

## Structure
- No shared package. Localparams: CL_S_COUNT=$clog2(S_COUNT), CNT_WIDTH=$clog2(MAX_OUTSTANDING+1), STATE_IDLE/STATE_WAIT.
- One sub-module: axi_read_arbiter_rr, a combinational round-robin pick taking (request vector, last_grant) and returning (grant_valid, grant_index).
- The counter array and R demux live in the top level.

## Test plan
- Single port: port 0 sends AR addr 0x1000, len 3, id 0x5 → m_arid=0x005, m_araddr=0x1000 one cycle after s_arready. R beats with rid 0x005 reach port 0 only, with rid=0x5.
- Fairness: ports 0 and 1 hold arvalid continuously and m_arready=1 → grants alternate 0,1,0,1, one grant every 2 cycles.
- Limit: MAX_OUTSTANDING=4, R stalled, port 1 issues 6 ARs → exactly 4 accepted and s_arready[1] stays low. One rlast to port 1 → the 5th AR is accepted.
- Simultaneous: AR accept and rlast on port 0 in the same cycle → cnt[0] unchanged (check against a model).
- Backpressure: m_arready held low 5 cycles → m_ar fields stable, no new s_arready; and s_rready[1]=0 with sel=1 → m_rready=0.
- Reset mid-operation: rst during WAIT with cnt[0]=2 → next cycle m_arvalid=0, cnt=0, and port 0 wins the next arbitration.
